rob_multi_commit: RTL and testbench
===================================

Name: rob_multi_commit

Overview:
Parametrised reorder buffer; next generation of the single-commit ROB. Allocates entries in program order from the dispatcher and accepts results from CDB_PORTS result buses. Retires up to COMMIT_W in-order entries per cycle to the register file and predictor, and flushes itself on a branch mispredict. Sits between dispatcher, ALU/LSB CDBs, regfile and branch predictor.

Parameters:
ROB_DEPTH, 16, entry count; power of two, >=4; all ids 0..ROB_DEPTH-1 usable
IDX_W, $clog2(ROB_DEPTH), entry id width
DATA_W, 32, data/pc width
REG_W, 5, architectural register index width
CDB_PORTS, 2, number of result buses (1..4)
COMMIT_W, 2, max retirements per cycle (1 or 2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
rdy  in  1  global enable; 0 = pause
alloc_valid  in  1  dispatcher allocates one entry
alloc_pc  in  DATA_W  instruction pc
alloc_rd  in  REG_W  destination register (0 = none)
alloc_is_branch  in  1  conditional branch
alloc_pred_taken  in  1  predicted direction
alloc_is_store  in  1  store instruction
alloc_id  out  IDX_W  id the next allocation receives (tail)
full  out  1  no free entry
free_cnt  out  IDX_W+1  free entries
qry_id  in  2*IDX_W  two operand-alias lookups
qry_rdy  out  2  lookup result ready
qry_val  out  2*DATA_W  lookup value
cdb_valid  in  CDB_PORTS  result valid per bus
cdb_id  in  CDB_PORTS*IDX_W  result entry id
cdb_val  in  CDB_PORTS*DATA_W  result value
cdb_taken  in  CDB_PORTS  actual branch direction
cdb_target  in  CDB_PORTS*DATA_W  branch taken target
store_at_head  out  1  head is a valid store (LSB may execute it)
commit_valid  out  COMMIT_W  regfile write per slot
commit_rd  out  COMMIT_W*REG_W  destination
commit_val  out  COMMIT_W*DATA_W  value
commit_id  out  COMMIT_W*IDX_W  retired id (regfile clears alias if matching)
pred_upd_valid  out  1  branch retired
pred_upd_pc  out  DATA_W  branch pc
pred_upd_taken  out  1  actual direction
flush  out  1  mispredict flush pulse
flush_pc  out  DATA_W  redirect pc

Behaviour:
- Reset: head=tail=0, count=0, all ready bits 0; every output 0 except free_cnt=ROB_DEPTH.
- rdy=0: all state frozen; commit_valid, pred_upd_valid and flush clear to 0 at the next edge.
- full = (count==ROB_DEPTH), computed from the registered count; no same-cycle credit for retirement. alloc_valid while full is ignored (bench error).
- Allocation: writes the tail entry and clears its ready bit; tail = (tail+1) mod ROB_DEPTH (natural wrap).
- CDB: for each valid port, sets ready[id] and stores val, taken and target. Duplicate ids in one cycle are illegal; the higher port index wins.
- Query is combinational: rdy = ready[id] OR any same-cycle cdb_valid with matching id. On a CDB hit, the value comes from the lowest matching port; otherwise from the array.
- Commit selection is combinational; outputs are registered, one cycle after selection.
  - Slot0 retires the head if count>0 and ready[head].
  - Slot1 (COMMIT_W=2) retires head+1 only if: slot0 retires; head is not a branch; head+1 is valid, ready and not a store.
- Per retired slot: commit_valid=1 only if rd!=0; commit_id = entry id. The entry always frees; count -= retired, plus 1 if allocated that cycle.
- Branch retire: pred_upd_valid=1, pred_upd_pc, pred_upd_taken = actual direction.
- Mispredict (actual != predicted):
  - Next cycle: flush=1 for exactly one cycle; flush_pc = taken ? target : pc+4.
  - On the same edge: head=tail=0, count=0, all ready cleared; that cycle's alloc and CDB writes are discarded.
  - During the flush-high cycle, alloc/CDB inputs are ignored.
- store_at_head = count>0 and head entry is a store. A store retires through slot0 once its LSB CDB result marks it ready.
- Reset asserted mid-operation aborts immediately to reset state; no commit or flush pulse is produced.

Decomposition:
- Shared header: ROB_DEPTH, widths, and the entry field layout (pc, rd, is_branch, pred, is_store, taken, target, val).
- One sub-module: rob_commit_sel (combinational slot-eligibility and mispredict detection).

Test Plan:
- ROB_DEPTH=4: 4 allocs, no CDB -> full=1, free_cnt=0, alloc_id wraps to 0; 5th alloc ignored.
- Alloc ids 0,1 (rd 3,4); CDB port0 id0=0x11 and port1 id1=0x22 same cycle -> next cycle commit_valid=2'b11, rd 3/4, val 0x11/0x22.
- Branch id0 pred_taken=0 at pc 0x100, CDB taken=1 target 0x200, id1 ready -> slot0 only; pred_upd_valid=1; flush=1 one cycle, flush_pc=0x200; next cycle free_cnt=ROB_DEPTH.
- Correct branch pred_taken=1, taken=1 -> pred_upd_valid=1, flush stays 0, slot1 blocked that cycle.
- qry_id=2 unready while cdb port1 writes id2=0x55 -> same-cycle qry_rdy=1, qry_val=0x55.
- Entries 0,1 ready, rdy=0 for 3 cycles -> no commit pulses; rdy=1 -> commits, then rst mid-stream -> all outputs 0 at once.

Source files
------------

// File: rtl/rob_multi_commit_pkg.sv
// Shared defaults, entry flag layout and the mispredict helper for the multi-commit reorder buffer.
package rob_multi_commit_pkg;

   localparam int ROB_DEPTH_DEF = 16;
   localparam int DATA_W_DEF    = 32;
   localparam int REG_W_DEF     = 5;
   localparam int CDB_PORTS_DEF = 2;
   localparam int COMMIT_W_DEF  = 2;

   // Per-entry control bits; pc, rd, val and target live in parameter-sized arrays beside these.
   typedef struct packed {
      logic is_branch;
      logic pred_taken;
      logic is_store;
      logic taken;
   } rob_flags_t;

   function automatic logic mispredicted(input logic is_branch, input logic pred_taken,
                                         input logic taken);
      return is_branch & (pred_taken ^ taken);
   endfunction

endpackage

// File: rtl/rob_multi_commit_if.sv
// Dispatcher, CDB, query and retirement bundle of the reorder buffer.
interface rob_multi_commit_if
   import rob_multi_commit_pkg::*;
#(
   parameter int ROB_DEPTH = ROB_DEPTH_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int REG_W     = REG_W_DEF,
   parameter int CDB_PORTS = CDB_PORTS_DEF,
   parameter int COMMIT_W  = COMMIT_W_DEF
) ();
   localparam int IDX_W = $clog2(ROB_DEPTH);

   logic                          alloc_valid;
   logic [DATA_W-1:0]             alloc_pc;
   logic [REG_W-1:0]              alloc_rd;
   logic                          alloc_is_branch;
   logic                          alloc_pred_taken;
   logic                          alloc_is_store;
   logic [IDX_W-1:0]              alloc_id;
   logic                          full;
   logic [IDX_W:0]                free_cnt;
   logic [2*IDX_W-1:0]            qry_id;
   logic [1:0]                    qry_rdy;
   logic [2*DATA_W-1:0]           qry_val;
   logic [CDB_PORTS-1:0]          cdb_valid;
   logic [CDB_PORTS*IDX_W-1:0]    cdb_id;
   logic [CDB_PORTS*DATA_W-1:0]   cdb_val;
   logic [CDB_PORTS-1:0]          cdb_taken;
   logic [CDB_PORTS*DATA_W-1:0]   cdb_target;
   logic                          store_at_head;
   logic [COMMIT_W-1:0]           commit_valid;
   logic [COMMIT_W*REG_W-1:0]     commit_rd;
   logic [COMMIT_W*DATA_W-1:0]    commit_val;
   logic [COMMIT_W*IDX_W-1:0]     commit_id;
   logic                          pred_upd_valid;
   logic [DATA_W-1:0]             pred_upd_pc;
   logic                          pred_upd_taken;
   logic                          flush;
   logic [DATA_W-1:0]             flush_pc;

   modport slave (
      input  alloc_valid, alloc_pc, alloc_rd, alloc_is_branch, alloc_pred_taken, alloc_is_store,
      input  qry_id, cdb_valid, cdb_id, cdb_val, cdb_taken, cdb_target,
      output alloc_id, full, free_cnt, qry_rdy, qry_val, store_at_head,
      output commit_valid, commit_rd, commit_val, commit_id,
      output pred_upd_valid, pred_upd_pc, pred_upd_taken, flush, flush_pc
   );

   modport master (
      output alloc_valid, alloc_pc, alloc_rd, alloc_is_branch, alloc_pred_taken, alloc_is_store,
      output qry_id, cdb_valid, cdb_id, cdb_val, cdb_taken, cdb_target,
      input  alloc_id, full, free_cnt, qry_rdy, qry_val, store_at_head,
      input  commit_valid, commit_rd, commit_val, commit_id,
      input  pred_upd_valid, pred_upd_pc, pred_upd_taken, flush, flush_pc
   );
endinterface

// File: rtl/rob_commit_sel.sv
// Decides which of the two oldest entries retire this cycle and whether the head branch mispredicted.
module rob_commit_sel
   import rob_multi_commit_pkg::*;
#(
   parameter int IDX_W    = 4,
   parameter int COMMIT_W = 2
) (
   input  logic [IDX_W:0] count,
   input  logic           head_ready,
   input  logic           head_is_branch,
   input  logic           head_pred_taken,
   input  logic           head_taken,
   input  logic           next_ready,
   input  logic           next_is_store,
   output logic           ret0,
   output logic           ret1,
   output logic           mispredict
);
   localparam logic DUAL_C = (COMMIT_W > 32'sd1);

   // Slot1 never passes a branch (its outcome may squash the younger entry) nor retires a store.
   always_comb begin
      ret0       = (count != '0) & head_ready;
      ret1       = DUAL_C & ret0 & ~head_is_branch & (count >= (IDX_W+1)'(2'd2))
                   & next_ready & ~next_is_store;
      mispredict = ret0 & mispredicted(head_is_branch, head_pred_taken, head_taken);
   end
endmodule

// File: rtl/rob_multi_commit.sv
// Reorder buffer: in-order allocation, out-of-order CDB completion, up to COMMIT_W in-order
// retirements per cycle, self-flush on branch mispredict.
module rob_multi_commit
   import rob_multi_commit_pkg::*;
#(
   parameter int ROB_DEPTH = ROB_DEPTH_DEF,
   parameter int IDX_W     = $clog2(ROB_DEPTH),
   parameter int DATA_W    = DATA_W_DEF,
   parameter int REG_W     = REG_W_DEF,
   parameter int CDB_PORTS = CDB_PORTS_DEF,
   parameter int COMMIT_W  = COMMIT_W_DEF
) (
   input logic               clk,
   input logic               rst,
   input logic               rdy,
   rob_multi_commit_if.slave bus
);
   localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(ROB_DEPTH);

   logic [IDX_W-1:0]  head_r;
   logic [IDX_W-1:0]  tail_r;
   logic [IDX_W:0]    count_r;
   logic [ROB_DEPTH-1:0] ready_r;
   logic [DATA_W-1:0] pc_r     [ROB_DEPTH];
   logic [DATA_W-1:0] val_r    [ROB_DEPTH];
   logic [DATA_W-1:0] target_r [ROB_DEPTH];
   logic [REG_W-1:0]  rd_r     [ROB_DEPTH];
   rob_flags_t        flags_r  [ROB_DEPTH];

   logic [COMMIT_W-1:0]             commit_valid_r;
   logic [COMMIT_W-1:0][REG_W-1:0]  commit_rd_r;
   logic [COMMIT_W-1:0][DATA_W-1:0] commit_val_r;
   logic [COMMIT_W-1:0][IDX_W-1:0]  commit_id_r;
   logic              pred_upd_valid_r;
   logic [DATA_W-1:0] pred_upd_pc_r;
   logic              pred_upd_taken_r;
   logic              flush_r;
   logic [DATA_W-1:0] flush_pc_r;

   logic [IDX_W-1:0]  head1_s;
   logic [IDX_W-1:0]  slot_id_s [COMMIT_W];
   logic              ret0_s;
   logic              ret1_s;
   logic [1:0]        ret_s;
   logic              mispredict_s;
   logic              full_s;
   logic              alloc_ok_s;
   logic [IDX_W:0]    ret_cnt_s;
   logic [IDX_W:0]    count_next_s;
   logic [IDX_W-1:0]  qid_s [2];
   logic [CDB_PORTS-1:0] cdb_hit_s [2];
   logic [1:0]              qry_rdy_s;
   logic [1:0][DATA_W-1:0]  qry_val_s;

   assign head1_s      = head_r + IDX_W'(1'b1);
   assign full_s       = (count_r == DEPTH_C);
   assign alloc_ok_s   = bus.alloc_valid & ~full_s & ~flush_r;
   assign ret_s        = {ret1_s, ret0_s};
   assign ret_cnt_s    = {{IDX_W{1'b0}}, ret0_s} + {{IDX_W{1'b0}}, ret1_s};
   assign count_next_s = count_r - ret_cnt_s + {{IDX_W{1'b0}}, alloc_ok_s};

   rob_commit_sel #(.IDX_W(IDX_W), .COMMIT_W(COMMIT_W)) u_sel (
      .count           (count_r),
      .head_ready      (ready_r[head_r]),
      .head_is_branch  (flags_r[head_r].is_branch),
      .head_pred_taken (flags_r[head_r].pred_taken),
      .head_taken      (flags_r[head_r].taken),
      .next_ready      (ready_r[head1_s]),
      .next_is_store   (flags_r[head1_s].is_store),
      .ret0            (ret0_s),
      .ret1            (ret1_s),
      .mispredict      (mispredict_s)
   );

   // Entry id examined by each commit slot.
   always_comb begin
      for (int s = 0; s < COMMIT_W; s++) begin
         slot_id_s[s] = head_r + IDX_W'(s);
      end
   end

   // Operand lookup with same-cycle CDB bypass; scanning high to low leaves the lowest port's value.
   always_comb begin
      qry_rdy_s = '0;
      qry_val_s = '0;
      for (int q = 0; q < 2; q++) begin
         qid_s[q]     = bus.qry_id[q*IDX_W +: IDX_W];
         qry_rdy_s[q] = ready_r[qid_s[q]];
         qry_val_s[q] = val_r[qid_s[q]];
         cdb_hit_s[q] = '0;
         for (int p = CDB_PORTS - 1; p >= 0; p--) begin
            cdb_hit_s[q][p] = bus.cdb_valid[p] & (bus.cdb_id[p*IDX_W +: IDX_W] == qid_s[q]);
            qry_rdy_s[q]    = qry_rdy_s[q] | cdb_hit_s[q][p];
            qry_val_s[q]    = cdb_hit_s[q][p] ? bus.cdb_val[p*DATA_W +: DATA_W] : qry_val_s[q];
         end
      end
   end

   // Entry storage, pointers and registered retirement/flush outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_r           <= '0;
         tail_r           <= '0;
         count_r          <= '0;
         ready_r          <= '0;
         for (int i = 0; i < ROB_DEPTH; i++) begin
            pc_r[i]     <= '0;
            val_r[i]    <= '0;
            target_r[i] <= '0;
            rd_r[i]     <= '0;
            flags_r[i]  <= '0;
         end
         commit_valid_r   <= '0;
         commit_rd_r      <= '0;
         commit_val_r     <= '0;
         commit_id_r      <= '0;
         pred_upd_valid_r <= 1'b0;
         pred_upd_pc_r    <= '0;
         pred_upd_taken_r <= 1'b0;
         flush_r          <= 1'b0;
         flush_pc_r       <= '0;
      end else if (rdy) begin
         flush_r          <= mispredict_s;
         pred_upd_valid_r <= ret0_s & flags_r[head_r].is_branch;
         if (ret0_s & flags_r[head_r].is_branch) begin
            pred_upd_pc_r    <= pc_r[head_r];
            pred_upd_taken_r <= flags_r[head_r].taken;
         end
         if (mispredict_s) begin
            flush_pc_r <= flags_r[head_r].taken ? target_r[head_r]
                                                : pc_r[head_r] + DATA_W'(3'd4);
         end
         for (int s = 0; s < COMMIT_W; s++) begin
            commit_valid_r[s] <= ret_s[s] & (rd_r[slot_id_s[s]] != '0);
            commit_rd_r[s]    <= ret_s[s] ? rd_r[slot_id_s[s]]  : '0;
            commit_val_r[s]   <= ret_s[s] ? val_r[slot_id_s[s]] : '0;
            commit_id_r[s]    <= ret_s[s] ? slot_id_s[s]        : '0;
         end
         if (mispredict_s) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
            ready_r <= '0;
         end else begin
            head_r  <= head_r + ret_cnt_s[IDX_W-1:0];
            count_r <= count_next_s;
            if (alloc_ok_s) begin
               pc_r[tail_r]    <= bus.alloc_pc;
               rd_r[tail_r]    <= bus.alloc_rd;
               flags_r[tail_r] <= '{is_branch: bus.alloc_is_branch,
                                    pred_taken: bus.alloc_pred_taken,
                                    is_store: bus.alloc_is_store, taken: 1'b0};
               ready_r[tail_r] <= 1'b0;
               tail_r          <= tail_r + IDX_W'(1'b1);
            end
            // Later ports overwrite earlier ones when ids collide.
            if (!flush_r) begin
               for (int p = 0; p < CDB_PORTS; p++) begin
                  if (bus.cdb_valid[p]) begin
                     ready_r[bus.cdb_id[p*IDX_W +: IDX_W]]        <= 1'b1;
                     val_r[bus.cdb_id[p*IDX_W +: IDX_W]]          <= bus.cdb_val[p*DATA_W +: DATA_W];
                     target_r[bus.cdb_id[p*IDX_W +: IDX_W]]       <= bus.cdb_target[p*DATA_W +: DATA_W];
                     flags_r[bus.cdb_id[p*IDX_W +: IDX_W]].taken  <= bus.cdb_taken[p];
                  end
               end
            end
         end
      end else begin
         commit_valid_r   <= '0;
         pred_upd_valid_r <= 1'b0;
         flush_r          <= 1'b0;
      end
   end

   assign bus.alloc_id       = tail_r;
   assign bus.full           = full_s;
   assign bus.free_cnt       = DEPTH_C - count_r;
   assign bus.qry_rdy        = qry_rdy_s;
   assign bus.qry_val        = qry_val_s;
   assign bus.store_at_head  = (count_r != '0) & flags_r[head_r].is_store;
   assign bus.commit_valid   = commit_valid_r;
   assign bus.commit_rd      = commit_rd_r;
   assign bus.commit_val     = commit_val_r;
   assign bus.commit_id      = commit_id_r;
   assign bus.pred_upd_valid = pred_upd_valid_r;
   assign bus.pred_upd_pc    = pred_upd_pc_r;
   assign bus.pred_upd_taken = pred_upd_taken_r;
   assign bus.flush          = flush_r;
   assign bus.flush_pc       = flush_pc_r;
endmodule

// File: tb/tb_rob_multi_commit.sv
// Directed bench for a 4-entry rob_multi_commit; retirements are matched against a scoreboard queue.
module tb_rob_multi_commit;
   localparam int DEPTH = 4;
   localparam int IW    = 2;
   localparam int DW    = 32;
   localparam int RW    = 5;
   localparam int CW    = 2;

   logic clk = 1'b0;
   logic rst;
   logic rdy;
   int   n_chk  = 0;
   int   n_fail = 0;

   typedef struct {
      logic [RW-1:0] rd;
      logic [DW-1:0] val;
      logic [IW-1:0] id;
   } exp_t;
   exp_t sb_q[$];

   rob_multi_commit_if #(.ROB_DEPTH(DEPTH)) bus ();
   rob_multi_commit #(.ROB_DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .rdy(rdy), .bus(bus.slave));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic sb_check();
      for (int s = 0; s < CW; s++) begin
         if (bus.commit_valid[s] === 1'b1) begin
            check("sb_pending", 64'(sb_q.size() > 0), 64'd1);
            if (sb_q.size() > 0) begin
               exp_t e;
               e = sb_q.pop_front();
               check("sb_rd", 64'(bus.commit_rd[s*RW +: RW]), 64'(e.rd));
               check("sb_val", 64'(bus.commit_val[s*DW +: DW]), 64'(e.val));
               check("sb_id", 64'(bus.commit_id[s*IW +: IW]), 64'(e.id));
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      sb_check();
   endtask

   task automatic clear_inputs();
      bus.alloc_valid      = 1'b0;
      bus.alloc_pc         = '0;
      bus.alloc_rd         = '0;
      bus.alloc_is_branch  = 1'b0;
      bus.alloc_pred_taken = 1'b0;
      bus.alloc_is_store   = 1'b0;
      bus.cdb_valid        = '0;
      bus.cdb_id           = '0;
      bus.cdb_val          = '0;
      bus.cdb_taken        = '0;
      bus.cdb_target       = '0;
   endtask

   task automatic alloc(input logic [DW-1:0] pc, input logic [RW-1:0] rd, input logic br,
                        input logic pred, input logic st);
      bus.alloc_valid      = 1'b1;
      bus.alloc_pc         = pc;
      bus.alloc_rd         = rd;
      bus.alloc_is_branch  = br;
      bus.alloc_pred_taken = pred;
      bus.alloc_is_store   = st;
      tick();
      bus.alloc_valid      = 1'b0;
   endtask

   task automatic cdb_set(input int p, input logic [IW-1:0] id, input logic [DW-1:0] val,
                          input logic tk, input logic [DW-1:0] tgt);
      bus.cdb_valid[p]             = 1'b1;
      bus.cdb_id[p*IW +: IW]       = id;
      bus.cdb_val[p*DW +: DW]      = val;
      bus.cdb_taken[p]             = tk;
      bus.cdb_target[p*DW +: DW]   = tgt;
   endtask

   task automatic expect_commit(input logic [RW-1:0] rd, input logic [DW-1:0] val,
                                input logic [IW-1:0] id);
      exp_t e;
      e.rd  = rd;
      e.val = val;
      e.id  = id;
      sb_q.push_back(e);
   endtask

   initial begin
      rst = 1'b1;
      rdy = 1'b1;
      clear_inputs();
      bus.qry_id = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_alloc_id", 64'(bus.alloc_id), 64'd0);
      check("rst_full", 64'(bus.full), 64'd0);
      check("rst_free_cnt", 64'(bus.free_cnt), 64'd4);
      check("rst_commit_valid", 64'(bus.commit_valid), 64'd0);
      check("rst_flush", 64'(bus.flush), 64'd0);
      check("rst_pred_upd", 64'(bus.pred_upd_valid), 64'd0);
      check("rst_store_head", 64'(bus.store_at_head), 64'd0);
      check("rst_qry_rdy", 64'(bus.qry_rdy), 64'd0);
      check("rst_qry_val", bus.qry_val, 64'd0);
      rst = 1'b0;

      // Fill to full, then an ignored fifth allocation.
      for (int i = 0; i < 4; i++) begin
         alloc(32'h10 + 32'(i * 4), 5'(i + 1), 1'b0, 1'b0, 1'b0);
         check("fill_alloc_id", 64'(bus.alloc_id), 64'((i + 1) % 4));
      end
      check("full_flag", 64'(bus.full), 64'd1);
      check("full_free_cnt", 64'(bus.free_cnt), 64'd0);
      alloc(32'h50, 5'd9, 1'b0, 1'b0, 1'b0);
      check("full_ignore_free", 64'(bus.free_cnt), 64'd0);
      check("full_ignore_id", 64'(bus.alloc_id), 64'd0);
      cdb_set(0, 2'd0, 32'hA0, 1'b0, 32'h0);
      cdb_set(1, 2'd1, 32'hA1, 1'b0, 32'h0);
      expect_commit(5'd1, 32'hA0, 2'd0);
      expect_commit(5'd2, 32'hA1, 2'd1);
      tick();
      clear_inputs();
      cdb_set(0, 2'd2, 32'hA2, 1'b0, 32'h0);
      cdb_set(1, 2'd3, 32'hA3, 1'b0, 32'h0);
      expect_commit(5'd3, 32'hA2, 2'd2);
      expect_commit(5'd4, 32'hA3, 2'd3);
      tick();
      clear_inputs();
      tick();
      tick();
      check("drain_free_cnt", 64'(bus.free_cnt), 64'd4);
      check("drain_sb_empty", 64'(sb_q.size()), 64'd0);

      // Two results on separate ports retire together.
      alloc(32'h20, 5'd3, 1'b0, 1'b0, 1'b0);
      alloc(32'h24, 5'd4, 1'b0, 1'b0, 1'b0);
      cdb_set(0, 2'd0, 32'h11, 1'b0, 32'h0);
      cdb_set(1, 2'd1, 32'h22, 1'b0, 32'h0);
      expect_commit(5'd3, 32'h11, 2'd0);
      expect_commit(5'd4, 32'h22, 2'd1);
      tick();
      clear_inputs();
      tick();
      check("dual_valid", 64'(bus.commit_valid), 64'b11);
      check("dual_rd", 64'(bus.commit_rd), 64'({5'd4, 5'd3}));
      check("dual_val", bus.commit_val, {32'h22, 32'h11});
      tick();
      check("dual_after", 64'(bus.commit_valid), 64'd0);

      // Query bypass from a same-cycle CDB write.
      alloc(32'h40, 5'd5, 1'b0, 1'b0, 1'b0);
      bus.qry_id = {2'd0, 2'd2};
      #1;
      check("qry_unready", 64'(bus.qry_rdy[0]), 64'd0);
      cdb_set(1, 2'd2, 32'h55, 1'b0, 32'h0);
      #1;
      check("qry_bypass_rdy", 64'(bus.qry_rdy[0]), 64'd1);
      check("qry_bypass_val", 64'(bus.qry_val[31:0]), 64'h55);
      expect_commit(5'd5, 32'h55, 2'd2);
      tick();
      clear_inputs();
      #1;
      check("qry_array_rdy", 64'(bus.qry_rdy[0]), 64'd1);
      check("qry_array_val", 64'(bus.qry_val[31:0]), 64'h55);
      tick();

      // Mispredicted branch at id3 with a ready younger entry at id0.
      alloc(32'h100, 5'd0, 1'b1, 1'b0, 1'b0);
      alloc(32'h104, 5'd6, 1'b0, 1'b0, 1'b0);
      cdb_set(0, 2'd3, 32'h0, 1'b1, 32'h200);
      cdb_set(1, 2'd0, 32'h66, 1'b0, 32'h0);
      tick();
      clear_inputs();
      tick();
      check("mis_commit_valid", 64'(bus.commit_valid), 64'd0);
      check("mis_pred_valid", 64'(bus.pred_upd_valid), 64'd1);
      check("mis_pred_pc", 64'(bus.pred_upd_pc), 64'h100);
      check("mis_pred_taken", 64'(bus.pred_upd_taken), 64'd1);
      check("mis_flush", 64'(bus.flush), 64'd1);
      check("mis_flush_pc", 64'(bus.flush_pc), 64'h200);
      check("mis_free_cnt", 64'(bus.free_cnt), 64'd4);
      bus.alloc_valid = 1'b1;
      bus.alloc_pc    = 32'h999;
      bus.alloc_rd    = 5'd15;
      tick();
      clear_inputs();
      check("flush_one_cycle", 64'(bus.flush), 64'd0);
      check("flush_alloc_drop", 64'(bus.free_cnt), 64'd4);
      check("flush_alloc_id", 64'(bus.alloc_id), 64'd0);
      check("flush_pred_clear", 64'(bus.pred_upd_valid), 64'd0);

      // Correctly predicted branch blocks slot1 for one cycle.
      alloc(32'h300, 5'd0, 1'b1, 1'b1, 1'b0);
      alloc(32'h304, 5'd7, 1'b0, 1'b0, 1'b0);
      cdb_set(0, 2'd0, 32'h0, 1'b1, 32'h400);
      cdb_set(1, 2'd1, 32'h77, 1'b0, 32'h0);
      expect_commit(5'd7, 32'h77, 2'd1);
      tick();
      clear_inputs();
      tick();
      check("br_ok_pred_valid", 64'(bus.pred_upd_valid), 64'd1);
      check("br_ok_pred_pc", 64'(bus.pred_upd_pc), 64'h300);
      check("br_ok_taken", 64'(bus.pred_upd_taken), 64'd1);
      check("br_ok_no_flush", 64'(bus.flush), 64'd0);
      check("br_ok_slot1_blk", 64'(bus.commit_valid), 64'd0);
      tick();
      check("br_ok_next", 64'(bus.commit_valid), 64'b01);
      check("br_ok_pred_clr", 64'(bus.pred_upd_valid), 64'd0);

      // Store at head waits for its result, then retires alongside a younger entry.
      alloc(32'h500, 5'd0, 1'b0, 1'b0, 1'b1);
      check("st_head", 64'(bus.store_at_head), 64'd1);
      alloc(32'h504, 5'd8, 1'b0, 1'b0, 1'b0);
      cdb_set(0, 2'd3, 32'h88, 1'b0, 32'h0);
      expect_commit(5'd8, 32'h88, 2'd3);
      tick();
      clear_inputs();
      tick();
      check("st_wait", 64'(bus.commit_valid), 64'd0);
      check("st_wait_head", 64'(bus.store_at_head), 64'd1);
      cdb_set(1, 2'd2, 32'h0, 1'b0, 32'h0);
      tick();
      clear_inputs();
      tick();
      check("st_pair", 64'(bus.commit_valid), 64'b10);
      check("st_gone", 64'(bus.store_at_head), 64'd0);

      // A store in slot1 is held back for the following cycle.
      alloc(32'h600, 5'd9, 1'b0, 1'b0, 1'b0);
      alloc(32'h604, 5'd0, 1'b0, 1'b0, 1'b1);
      cdb_set(0, 2'd0, 32'h99, 1'b0, 32'h0);
      cdb_set(1, 2'd1, 32'h0, 1'b0, 32'h0);
      expect_commit(5'd9, 32'h99, 2'd0);
      tick();
      clear_inputs();
      tick();
      check("st1_blk_valid", 64'(bus.commit_valid), 64'b01);
      check("st1_blk_head", 64'(bus.store_at_head), 64'd1);
      tick();
      check("st1_ret_valid", 64'(bus.commit_valid), 64'd0);
      check("st1_ret_head", 64'(bus.store_at_head), 64'd0);
      check("st1_free_cnt", 64'(bus.free_cnt), 64'd4);

      // Pause with ready entries, then resume.
      alloc(32'h700, 5'd10, 1'b0, 1'b0, 1'b0);
      alloc(32'h704, 5'd11, 1'b0, 1'b0, 1'b0);
      cdb_set(0, 2'd2, 32'hAA, 1'b0, 32'h0);
      cdb_set(1, 2'd3, 32'hBB, 1'b0, 32'h0);
      expect_commit(5'd10, 32'hAA, 2'd2);
      expect_commit(5'd11, 32'hBB, 2'd3);
      tick();
      clear_inputs();
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("pause_no_commit", 64'(bus.commit_valid), 64'd0);
         check("pause_free_cnt", 64'(bus.free_cnt), 64'd2);
      end
      rdy = 1'b1;
      tick();
      check("resume_commit", 64'(bus.commit_valid), 64'b11);

      // Reset while commits are on the outputs.
      alloc(32'h800, 5'd12, 1'b0, 1'b0, 1'b0);
      alloc(32'h804, 5'd13, 1'b0, 1'b0, 1'b0);
      alloc(32'h808, 5'd14, 1'b0, 1'b0, 1'b0);
      cdb_set(0, 2'd0, 32'hC0, 1'b0, 32'h0);
      cdb_set(1, 2'd1, 32'hC1, 1'b0, 32'h0);
      expect_commit(5'd12, 32'hC0, 2'd0);
      expect_commit(5'd13, 32'hC1, 2'd1);
      tick();
      clear_inputs();
      tick();
      check("prerst_commit", 64'(bus.commit_valid), 64'b11);
      #2;
      rst = 1'b1;
      #1;
      check("midrst_commit", 64'(bus.commit_valid), 64'd0);
      check("midrst_val", bus.commit_val, 64'd0);
      check("midrst_free_cnt", 64'(bus.free_cnt), 64'd4);
      check("midrst_alloc_id", 64'(bus.alloc_id), 64'd0);
      check("midrst_flush", 64'(bus.flush), 64'd0);
      tick();
      rst = 1'b0;
      tick();
      check("postrst_commit", 64'(bus.commit_valid), 64'd0);
      check("final_sb_empty", 64'(sb_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
